// File: rtl/config_chain_loader.sv
// Serial configuration chain loader for an IO line: clears the chain, streams CHAIN_LEN bits LSB-first
// from a valid/ready word source and checks chain integrity from the returned config_out.
module config_chain_loader #(
    parameter int CHAIN_LEN    = 640,
    parameter int WORD_W       = 32,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [WORD_W-1:0]                word_data,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count,
    output logic                             config_in,
    output logic                             config_enable,
    output logic                             config_nreset,
    input  logic                             config_out
);

    localparam int BC_W  = $clog2(CHAIN_LEN + 1);
    localparam int WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WC_W  = $clog2(WORDS + 1);
    localparam int BB_W  = $clog2(WORD_W + 1);
    localparam int CC_W  = $clog2(CLEAR_CYCLES + 1);
    localparam int TAIL  = (CHAIN_LEN % WORD_W == 0) ? WORD_W : (CHAIN_LEN % WORD_W);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, CHECK} state_t;

    state_t            state, state_nxt;
    logic [CC_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [WORD_W-1:0] buf_data;
    logic [BB_W-1:0]   buf_bits, buf_bits_nxt;
    logic [WC_W-1:0]   words_acc, words_acc_nxt;
    logic              first_bit;

    logic              go, shift, accept, last_word;
    logic              word_ready_nxt, busy_nxt, done_nxt, error_nxt;
    logic [BC_W-1:0]   bit_count_nxt;
    logic              config_in_nxt, config_enable_nxt, config_nreset_nxt;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A start coinciding with the done pulse belongs to the load just finished and is dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start && !done) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == CC_W'(CLEAR_CYCLES - 1)) state_nxt = LOAD;
            LOAD:    if (bit_count == BC_W'(CHAIN_LEN)) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        go        = (state == IDLE) && start && !done;
        shift     = (state == LOAD) && (buf_bits != '0);
        accept    = (state == LOAD) && word_valid && word_ready;
        last_word = (words_acc == WC_W'(WORDS - 1));

        buf_bits_nxt = buf_bits;
        if (accept)     buf_bits_nxt = last_word ? BB_W'(TAIL) : BB_W'(WORD_W);
        else if (shift) buf_bits_nxt = buf_bits - 1'b1;

        words_acc_nxt = go ? '0 : words_acc + WC_W'(accept);
        clr_cnt_nxt   = (state == CLEAR) ? clr_cnt + 1'b1 : '0;

        // Ready one cycle ahead: a buffer holding a single bit drains in the same cycle a new word lands.
        word_ready_nxt = (state_nxt == LOAD) && (words_acc_nxt != WC_W'(WORDS)) &&
                         (buf_bits_nxt <= BB_W'(1));

        busy_nxt          = (state_nxt != IDLE);
        done_nxt          = (state == CHECK);
        config_nreset_nxt = (state_nxt != CLEAR);
        config_enable_nxt = shift;
        config_in_nxt     = shift & buf_data[0];
        bit_count_nxt     = go ? '0 : bit_count + BC_W'(shift);

        // During a shift the chain end must still show cleared zeros; after the last shift it must show first_bit.
        error_nxt = go ? 1'b0 :
                    (error | (config_enable & config_out) |
                     ((state == CHECK) & (config_out != first_bit)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            word_ready    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            bit_count     <= '0;
            config_in     <= 1'b0;
            config_enable <= 1'b0;
            config_nreset <= 1'b1;
            clr_cnt       <= '0;
            buf_bits      <= '0;
            words_acc     <= '0;
        end else begin
            word_ready    <= word_ready_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            error         <= error_nxt;
            bit_count     <= bit_count_nxt;
            config_in     <= config_in_nxt;
            config_enable <= config_enable_nxt;
            config_nreset <= config_nreset_nxt;
            clr_cnt       <= clr_cnt_nxt;
            buf_bits      <= buf_bits_nxt;
            words_acc     <= words_acc_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (accept)     buf_data <= word_data;
        else if (shift) buf_data <= buf_data >> 1;
        if (accept && (words_acc == '0)) first_bit <= word_data[0];
    end

endmodule
